// File: rtl/epochtv1_vram_arb.sv
// VRAM bank arbiter: two 2 KiB banks shared between CPU bus accesses and render fetches.
// The renderer always wins its bank; the CPU waits only while the renderer occupies its target bank.
module epochtv1_vram_arb #(
   parameter int unsigned STALL_MAX = 64
) (
   input  logic        CLK,
   input  logic        RESB,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [11:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_busy,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_starve,
   input  logic        ren_req,
   input  logic [11:0] ren_addr,
   output logic        ren_valid,
   output logic [7:0]  ren_rdata,
   output logic        vram_sel_cpu,
   output logic [10:0] vram_a_addr,
   output logic        vram_a_we,
   output logic [7:0]  vram_a_din,
   input  logic [7:0]  vram_a_dout,
   output logic [10:0] vram_b_addr,
   output logic        vram_b_we,
   output logic [7:0]  vram_b_din,
   input  logic [7:0]  vram_b_dout
);

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAITD, S_ACK} state_e;

   localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);

   state_e      state_q;
   logic        lat_we_q;
   logic [11:0] lat_addr_q;
   logic [7:0]  lat_wdata_q;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        starve_q;
   logic [7:0]  cpu_rdata_q;
   logic        ren_valid_q, ren_bank_q;
   logic [10:0] a_addr_q, b_addr_q;

   logic ren_a, ren_b, conflict, grant, grant_a, grant_b;

   assign ren_a    = ren_req & ~ren_addr[11];
   assign ren_b    = ren_req &  ren_addr[11];
   assign conflict = ren_req & (ren_addr[11] == lat_addr_q[11]);
   assign grant    = (state_q == S_PEND) & ~conflict;
   assign grant_a  = grant & ~lat_addr_q[11];
   assign grant_b  = grant &  lat_addr_q[11];

   // Renderer takes its bank first; an unused port keeps its previous address.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      vram_a_addr = a_addr_q;
      vram_a_we   = 1'b0;
      vram_a_din  = lat_wdata_q;
      vram_b_addr = b_addr_q;
      vram_b_we   = 1'b0;
      vram_b_din  = lat_wdata_q;
      if (ren_a) begin
         vram_a_addr = ren_addr[10:0];
      end else if (grant_a) begin
         vram_a_addr = lat_addr_q[10:0];
         vram_a_we   = lat_we_q;
      end
      if (ren_b) begin
         vram_b_addr = ren_addr[10:0];
      end else if (grant_b) begin
         vram_b_addr = lat_addr_q[10:0];
         vram_b_we   = lat_we_q;
      end
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (state_q == S_ACK) begin
         wait_cnt_d = 8'h00;
      end else if ((state_q == S_PEND) && !grant && (wait_cnt_q != 8'hFF)) begin
         wait_cnt_d = wait_cnt_q + 8'h01;
      end
   end

   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         state_q     <= S_IDLE;
         lat_we_q    <= 1'b0;
         lat_addr_q  <= 12'h000;
         lat_wdata_q <= 8'h00;
         cpu_rdata_q <= 8'h00;
      end else begin
         // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
         case (state_q)
            S_IDLE: begin
               if (cpu_req) begin
                  lat_we_q    <= cpu_we;
                  lat_addr_q  <= cpu_addr;
                  lat_wdata_q <= cpu_wdata;
                  state_q     <= S_PEND;
               end
            end
            S_PEND: begin
               if (grant) state_q <= lat_we_q ? S_ACK : S_WAITD;
            end
            S_WAITD: begin
               cpu_rdata_q <= lat_addr_q[11] ? vram_b_dout : vram_a_dout;
               state_q     <= S_ACK;
            end
            S_ACK:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         wait_cnt_q  <= 8'h00;
         starve_q    <= 1'b0;
         ren_valid_q <= 1'b0;
         ren_bank_q  <= 1'b0;
         a_addr_q    <= 11'h000;
         b_addr_q    <= 11'h000;
      end else begin
         wait_cnt_q  <= wait_cnt_d;
         if (wait_cnt_d > STALL_LIM) starve_q <= 1'b1;
         ren_valid_q <= ren_req;
         ren_bank_q  <= ren_addr[11];
         a_addr_q    <= vram_a_addr;
         b_addr_q    <= vram_b_addr;
      end
   end

   assign cpu_busy     = (state_q != S_IDLE);
   assign cpu_ack      = (state_q == S_ACK);
   assign cpu_rdata    = cpu_rdata_q;
   assign cpu_starve   = starve_q;
   assign vram_sel_cpu = grant;
   assign ren_valid    = ren_valid_q;
   // Bank RAM output already carries the one-cycle read latency; only the bank choice is registered.
   assign ren_rdata    = ren_valid_q ? (ren_bank_q ? vram_b_dout : vram_a_dout) : 8'h00;

endmodule

// File: tb/tb_epochtv1_vram_arb.sv
// Directed bench for epochtv1_vram_arb: bank RAM models, a reference memory and a grant/ack timing model.
module tb_epochtv1_vram_arb;

   localparam int STALL_MAX = 8;

   logic        CLK = 1'b0;
   logic        RESB = 1'b0;
   logic        cpu_req, cpu_we;
   logic [11:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_busy, cpu_ack, cpu_starve;
   logic [7:0]  cpu_rdata;
   logic        ren_req;
   logic [11:0] ren_addr;
   logic        ren_valid;
   logic [7:0]  ren_rdata;
   logic        vram_sel_cpu;
   logic [10:0] vram_a_addr, vram_b_addr;
   logic        vram_a_we, vram_b_we;
   logic [7:0]  vram_a_din, vram_b_din, vram_a_dout, vram_b_dout;

   logic [7:0] bank_a [2048];
   logic [7:0] bank_b [2048];
   logic [7:0] exp_mem [4096];

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   epochtv1_vram_arb #(.STALL_MAX(STALL_MAX)) dut (
      .CLK(CLK), .RESB(RESB),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_starve(cpu_starve),
      .ren_req(ren_req), .ren_addr(ren_addr), .ren_valid(ren_valid), .ren_rdata(ren_rdata),
      .vram_sel_cpu(vram_sel_cpu),
      .vram_a_addr(vram_a_addr), .vram_a_we(vram_a_we), .vram_a_din(vram_a_din), .vram_a_dout(vram_a_dout),
      .vram_b_addr(vram_b_addr), .vram_b_we(vram_b_we), .vram_b_din(vram_b_din), .vram_b_dout(vram_b_dout)
   );

   // Synchronous-read bank RAMs, one cycle latency.
   always @(posedge CLK) begin
      if (vram_a_we) bank_a[vram_a_addr] <= vram_a_din;
      vram_a_dout <= bank_a[vram_a_addr];
      if (vram_b_we) bank_b[vram_b_addr] <= vram_b_din;
      vram_b_dout <= bank_b[vram_b_addr];
   end

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESB = 1'b0;
      cpu_req = 1'b0;
      ren_req = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESB = 1'b1;
   endtask

   task automatic drive_ren(input int c, input int ren_n, input logic [11:0] ren_a, input bit ren_rand);
      if (ren_rand) begin
         ren_req  = 1'($urandom_range(0, 1));
         ren_addr = 12'($urandom_range(0, 4095));
      end else begin
         ren_req  = (c < ren_n);
         ren_addr = ren_a;
      end
   endtask

   // One CPU access starting at cycle 0, with render traffic and a cycle-accurate grant model.
   task automatic run_access(input string tag, input logic we, input logic [11:0] addr,
                             input logic [7:0] wdata, input int ren_n, input logic [11:0] ren_a,
                             input bit ren_rand, input bit junk, input int exp_ack,
                             input int starve_from, output logic [7:0] rd);
      int c, grant_c, ack_c;
      bit pend, exp_sel, exp_ack_now, ren_prev;
      logic [7:0] ren_exp;
      c = 0; grant_c = -1; ack_c = -1; pend = 0; ren_prev = 0; ren_exp = 8'h00; rd = 8'h00;
      next_cycle();
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      drive_ren(c, ren_n, ren_a, ren_rand);
      while (ack_c < 0 && c < 300) begin
         @(negedge CLK);
         checks++;
         if (ren_valid !== ren_prev || (ren_prev && ren_rdata !== ren_exp)) begin
            errors++;
            $display("FAIL %s ren c%0d: valid=%b data=%h required valid=%b data=%h",
                     tag, c, ren_valid, ren_rdata, ren_prev, ren_exp);
         end
         if (ren_req) begin
            checks++;
            if (ren_addr[11] ? (vram_b_addr !== ren_addr[10:0] || vram_b_we !== 1'b0)
                             : (vram_a_addr !== ren_addr[10:0] || vram_a_we !== 1'b0)) begin
               errors++;
               $display("FAIL %s ren_port c%0d: a=%h/%b b=%h/%b required addr %h we 0",
                        tag, c, vram_a_addr, vram_a_we, vram_b_addr, vram_b_we, ren_addr);
            end
            ren_exp = exp_mem[ren_addr];
         end
         ren_prev = ren_req;
         exp_sel = pend && !(ren_req && (ren_addr[11] == addr[11]));
         checks++;
         if (vram_sel_cpu !== exp_sel) begin
            errors++;
            $display("FAIL %s sel c%0d: got %b required %b", tag, c, vram_sel_cpu, exp_sel);
         end
         if (exp_sel) begin
            grant_c = c;
            pend = 0;
            checks++;
            if (addr[11] ? (vram_b_addr !== addr[10:0] || vram_b_we !== we || vram_a_we !== 1'b0 ||
                            (we && vram_b_din !== wdata))
                         : (vram_a_addr !== addr[10:0] || vram_a_we !== we || vram_b_we !== 1'b0 ||
                            (we && vram_a_din !== wdata))) begin
               errors++;
               $display("FAIL %s cpu_port c%0d: a=%h/%b/%h b=%h/%b/%h required addr %h we %b din %h",
                        tag, c, vram_a_addr, vram_a_we, vram_a_din, vram_b_addr, vram_b_we,
                        vram_b_din, addr, we, wdata);
            end
            if (we) exp_mem[addr] = wdata;
         end
         exp_ack_now = (grant_c >= 0) && (c == grant_c + (we ? 1 : 2));
         checks++;
         if (cpu_ack !== exp_ack_now || cpu_busy !== (c >= 1)) begin
            errors++;
            $display("FAIL %s ack_busy c%0d: ack=%b busy=%b required ack=%b busy=%b",
                     tag, c, cpu_ack, cpu_busy, exp_ack_now, (c >= 1));
         end
         if (starve_from >= 0 && c >= 1) begin
            checks++;
            if (cpu_starve !== (c >= starve_from)) begin
               errors++;
               $display("FAIL %s starve c%0d: got %b required %b", tag, c, cpu_starve, (c >= starve_from));
            end
         end
         if (cpu_ack === 1'b1) begin
            ack_c = c;
            rd = cpu_rdata;
            if (!we) begin
               checks++;
               if (cpu_rdata !== exp_mem[addr]) begin
                  errors++;
                  $display("FAIL %s rdata: got %h required %h", tag, cpu_rdata, exp_mem[addr]);
               end
            end
         end else begin
            next_cycle();
            c++;
            if (c == 1) pend = 1;
            cpu_req = junk;
            if (junk) begin
               cpu_we = 1'b1; cpu_addr = addr ^ 12'h001; cpu_wdata = 8'hEE;
            end
            drive_ren(c, ren_n, ren_a, ren_rand);
         end
      end
      if (ack_c < 0) begin
         errors++;
         $display("FAIL %s timeout: no ack within %0d cycles", tag, c);
      end
      if (exp_ack >= 0) begin
         checks++;
         if (ack_c !== exp_ack) begin
            errors++;
            $display("FAIL %s ack_cycle: got %0d required %0d", tag, ack_c, exp_ack);
         end
      end
      next_cycle();
      cpu_req = 1'b0;
      ren_req = 1'b0;
      @(negedge CLK);
      checks++;
      if (cpu_busy !== 1'b0 || cpu_ack !== 1'b0 || ren_valid !== ren_prev ||
          (ren_prev && ren_rdata !== ren_exp)) begin
         errors++;
         $display("FAIL %s tail: busy=%b ack=%b ren_valid=%b ren_rdata=%h required 0 0 %b %h",
                  tag, cpu_busy, cpu_ack, ren_valid, ren_rdata, ren_prev, ren_exp);
      end
      if (starve_from >= 0) begin
         checks++;
         if (cpu_starve !== 1'b1) begin
            errors++;
            $display("FAIL %s starve_after_ack: got %b required 1", tag, cpu_starve);
         end
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({cpu_busy, cpu_ack, ren_valid, cpu_starve, vram_sel_cpu, vram_a_we, vram_b_we} !== 7'b0 ||
          cpu_rdata !== 8'h00 || ren_rdata !== 8'h00) begin
         errors++;
         $display("FAIL reset: busy=%b ack=%b rv=%b starve=%b sel=%b awe=%b bwe=%b rd=%h rr=%h required all 0",
                  cpu_busy, cpu_ack, ren_valid, cpu_starve, vram_sel_cpu, vram_a_we, vram_b_we,
                  cpu_rdata, ren_rdata);
      end
      do_reset();
   endtask

   task automatic test_write_read();
      logic [7:0] rd;
      run_access("t1_write", 1'b1, 12'h800, 8'h5A, 0, 12'h000, 0, 0, 2, -1, rd);
      run_access("t1_read", 1'b0, 12'h800, 8'h00, 0, 12'h000, 0, 0, 3, -1, rd);
      checks++;
      if (rd !== 8'h5A || bank_b[0] !== 8'h5A) begin
         errors++;
         $display("FAIL t1_value: rdata=%h bank_b[0]=%h required 5a", rd, bank_b[0]);
      end
   endtask

   task automatic test_other_bank();
      logic [7:0] rd;
      run_access("t2_read", 1'b0, 12'h900, 8'h00, 1000, 12'h123, 0, 0, 3, -1, rd);
   endtask

   task automatic test_conflict();
      logic [7:0] rd;
      run_access("t3_write", 1'b1, 12'h010, 8'hC3, 10, 12'h045, 0, 0, 11, -1, rd);
      checks++;
      if (bank_a[11'h010] !== 8'hC3) begin
         errors++;
         $display("FAIL t3_ram: bank_a[010]=%h required c3", bank_a[11'h010]);
      end
   endtask

   task automatic test_boundary_busy();
      logic [7:0] rd;
      run_access("bd_w7ff", 1'b1, 12'h7FF, 8'h11, 0, 12'h000, 0, 1, 2, -1, rd);
      run_access("bd_w800", 1'b1, 12'h800, 8'h22, 0, 12'h000, 0, 1, 2, -1, rd);
      run_access("bd_r7ff", 1'b0, 12'h7FF, 8'h00, 0, 12'h000, 0, 0, 3, -1, rd);
      run_access("bd_r800", 1'b0, 12'h800, 8'h00, 0, 12'h000, 0, 0, 3, -1, rd);
      checks++;
      if (bank_a[11'h7FF] !== 8'h11 || bank_b[11'h000] !== 8'h22 ||
          bank_a[11'h7FE] !== exp_mem[12'h7FE] || bank_b[11'h001] !== exp_mem[12'h801]) begin
         errors++;
         $display("FAIL bd_ram: a7ff=%h b000=%h a7fe=%h b001=%h required 11 22 %h %h",
                  bank_a[11'h7FF], bank_b[11'h000], bank_a[11'h7FE], bank_b[11'h001],
                  exp_mem[12'h7FE], exp_mem[12'h801]);
      end
   endtask

   task automatic test_mid_reset();
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h200; cpu_wdata = 8'h99;
      ren_req = 1'b1; ren_addr = 12'h300;
      next_cycle();
      cpu_req = 1'b0;
      @(negedge CLK);
      checks++;
      if (cpu_busy !== 1'b1 || vram_sel_cpu !== 1'b0) begin
         errors++;
         $display("FAIL mr_pend: busy=%b sel=%b required 1 0", cpu_busy, vram_sel_cpu);
      end
      RESB = 1'b0;
      ren_req = 1'b0;
      #1;
      checks++;
      if ({cpu_busy, cpu_ack, ren_valid, cpu_starve, vram_sel_cpu, vram_a_we, vram_b_we} !== 7'b0 ||
          cpu_rdata !== 8'h00 || ren_rdata !== 8'h00) begin
         errors++;
         $display("FAIL mr_outputs: busy=%b ack=%b rv=%b starve=%b sel=%b awe=%b bwe=%b rd=%h rr=%h required all 0",
                  cpu_busy, cpu_ack, ren_valid, cpu_starve, vram_sel_cpu, vram_a_we, vram_b_we,
                  cpu_rdata, ren_rdata);
      end
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESB = 1'b1;
      @(negedge CLK);
      checks++;
      if (bank_a[11'h200] !== exp_mem[12'h200] || cpu_busy !== 1'b0) begin
         errors++;
         $display("FAIL mr_ram: bank_a[200]=%h busy=%b required %h 0",
                  bank_a[11'h200], cpu_busy, exp_mem[12'h200]);
      end
   endtask

   task automatic test_starve();
      logic [7:0] rd;
      do_reset();
      run_access("t4_starve", 1'b0, 12'h800, 8'h00, 20, 12'h8A0, 0, 0, 22, 10, rd);
   endtask

   task automatic test_sweep();
      logic [7:0] rd, dummy;
      int nbad;
      for (int a = 0; a < 4096; a++) begin
         run_access("sw_read", 1'b0, 12'(a), 8'h00, 0, 12'h000, 1, 0, -1, -1, rd);
         run_access("sw_write", 1'b1, 12'(a), rd ^ 8'hA5, 0, 12'h000, 1, 0, -1, -1, dummy);
      end
      nbad = 0;
      for (int i = 0; i < 2048; i++) begin
         if (bank_a[i] !== exp_mem[i]) nbad++;
         if (bank_b[i] !== exp_mem[i + 2048]) nbad++;
      end
      checks++;
      if (nbad !== 0) begin
         errors++;
         $display("FAIL sw_ram: %0d bytes differ from model, required 0", nbad);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) exp_mem[i] = 8'((i * 37 + 5) & 255);
      for (int i = 0; i < 2048; i++) begin
         bank_a[i] = exp_mem[i];
         bank_b[i] = exp_mem[i + 2048];
      end
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h000; cpu_wdata = 8'h00;
      ren_req = 1'b0; ren_addr = 12'h000;
      test_reset();
      test_write_read();
      test_other_bank();
      test_conflict();
      test_boundary_busy();
      test_mid_reset();
      test_starve();
      test_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
